uart_rx_flex: RTL and testbench

- Parametrised successor UART receiver: runtime-programmable oversampling (any Prescale 4..63, not just 8/16/32).
- Adds 1 or 2 stop bits, start-glitch rejection, break detection, and a valid/ready output register with overrun flag.
- Sits between the pad-side serial RX line and the system data consumer; one frame = start, DATA_WIDTH data bits LSB-first, optional parity, 1-2 stop bits.

---
 rtl/uart_rx_flex_pkg.sv | 27 ++
 rtl/uart_rx_flex_sampler.sv | 51 +++++
 rtl/uart_rx_flex.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_flex.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_flex_pkg.sv
// Shared types, constants and helper functions for the flexible UART receiver.
package uart_rx_flex_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam int unsigned MIN_PRESCALE = 4;
    localparam int unsigned PRESCALE_W   = 6;
    localparam int unsigned BIT_CNT_W    = 4;
    localparam int unsigned MAX_DATA_W   = 9;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity bit the transmitter should have sent; data is zero-extended.
    function automatic logic exp_parity(input logic [MAX_DATA_W-1:0] data, input logic typ);
        return (^data) ^ typ;
    endfunction

endpackage

// File: rtl/uart_rx_flex_sampler.sv
// RX synchroniser, per-bit edge counter and 3-point majority sampler.
module uart_rx_flex_sampler
    import uart_rx_flex_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  rx_s,
    output logic                  bit_tick,
    output logic                  bit_val,
    output logic                  bit_end
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [PRESCALE_W-1:0]  cnt;
    logic [PRESCALE_W-1:0]  mid;
    logic                   s0;
    logic                   s1;

    assign mid  = prescale >> 1;
    assign rx_s = sync_q[SYNC_STAGES-1];

    // Presetting to 1 keeps the line idle-high out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            s0  <= 1'b1;
            s1  <= 1'b1;
        end else begin
            if (!enable || bit_end) cnt <= '0;
            else                    cnt <= cnt + PRESCALE_W'(1);
            if (enable && cnt == mid - PRESCALE_W'(1)) s0 <= rx_s;
            if (enable && cnt == mid)                  s1 <= rx_s;
        end
    end

    // Third sample is the live value at the tick itself.
    assign bit_tick = enable && (cnt == mid + PRESCALE_W'(1));
    assign bit_val  = maj3(s0, s1, rx_s);
    assign bit_end  = enable && (cnt == prescale - PRESCALE_W'(1));

endmodule

// File: rtl/uart_rx_flex.sv
// UART receiver with programmable oversampling, optional parity, 1-2 stop bits,
// glitch rejection, break detection and a valid/ready output register.
module uart_rx_flex
    import uart_rx_flex_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  RX_READY,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  Parity_Error,
    output logic                  Stop_Error,
    output logic                  Overrun_Error,
    output logic                  Break_Detect,
    output logic                  busy
);

    state_t                state;
    logic                  cfg_par_en;
    logic                  cfg_par_typ;
    logic                  cfg_stop2;
    logic [PRESCALE_W-1:0] cfg_p;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  par_bit;
    logic                  stop1;
    logic                  stop_all;
    logic                  stop_idx;

    logic                  rx_s;
    logic                  bit_tick;
    logic                  bit_val;
    logic                  bit_end;
    logic                  enable_c;
    logic [PRESCALE_W-1:0] prescale_c;
    logic                  stop1_c;
    logic                  stop_all_c;
    logic                  par_err_c;
    logic                  brk_c;

    assign prescale_c = (Prescale < PRESCALE_W'(MIN_PRESCALE)) ? PRESCALE_W'(MIN_PRESCALE) : Prescale;
    assign enable_c   = (state == ST_START) || (state == ST_DATA) ||
                        (state == ST_PARITY) || (state == ST_STOP);

    uart_rx_flex_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
        .clk      (CLK),
        .rst_n    (RST),
        .rx_in    (RX_IN),
        .enable   (enable_c),
        .prescale (cfg_p),
        .rx_s     (rx_s),
        .bit_tick (bit_tick),
        .bit_val  (bit_val),
        .bit_end  (bit_end)
    );

    // Frame verdict, valid at the final stop tick.
    assign stop1_c    = stop_idx ? stop1 : bit_val;
    assign stop_all_c = (stop_idx ? stop_all : 1'b1) & bit_val;
    assign par_err_c  = cfg_par_en && (par_bit != exp_parity(MAX_DATA_W'(shreg), cfg_par_typ));
    assign brk_c      = (shreg == '0) && (!cfg_par_en || !par_bit) && !stop1_c;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= ST_IDLE;
            cfg_par_en    <= 1'b0;
            cfg_par_typ   <= 1'b0;
            cfg_stop2     <= 1'b0;
            cfg_p         <= PRESCALE_W'(MIN_PRESCALE);
            shreg         <= '0;
            bit_cnt       <= '0;
            par_bit       <= 1'b0;
            stop1         <= 1'b0;
            stop_all      <= 1'b0;
            stop_idx      <= 1'b0;
            P_DATA        <= '0;
            data_valid    <= 1'b0;
            Parity_Error  <= 1'b0;
            Stop_Error    <= 1'b0;
            Overrun_Error <= 1'b0;
            Break_Detect  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            Parity_Error  <= 1'b0;
            Stop_Error    <= 1'b0;
            Overrun_Error <= 1'b0;
            Break_Detect  <= 1'b0;
            if (data_valid && RX_READY) data_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state       <= ST_START;
                        busy        <= 1'b1;
                        cfg_par_en  <= PAR_EN;
                        cfg_par_typ <= PAR_TYP;
                        cfg_stop2   <= STOP2;
                        cfg_p       <= prescale_c;
                        bit_cnt     <= '0;
                        stop_idx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_tick && bit_val) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (bit_end) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shreg   <= {bit_val, shreg[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1))
                            state <= cfg_par_en ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        par_bit <= bit_val;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (!stop_idx && cfg_stop2) begin
                            stop_idx <= 1'b1;
                            stop1    <= bit_val;
                            stop_all <= bit_val;
                        end else begin
                            state        <= ST_DONE;
                            Parity_Error <= par_err_c;
                            Stop_Error   <= !stop_all_c;
                            Break_Detect <= brk_c;
                            if (!par_err_c && stop_all_c) begin
                                if (!data_valid || RX_READY) begin
                                    P_DATA     <= shreg;
                                    data_valid <= 1'b1;
                                end else begin
                                    Overrun_Error <= 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_flex.sv
// Directed self-checking bench for uart_rx_flex (DATA_WIDTH=8, SYNC_STAGES=2).
module tb_uart_rx_flex;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STOP2;
    logic [5:0] Prescale;
    logic       RX_READY;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       Parity_Error;
    logic       Stop_Error;
    logic       Overrun_Error;
    logic       Break_Detect;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int pe_hi = 0, se_hi = 0, oe_hi = 0, bd_hi = 0, dv_hi = 0, dv_rise = 0;
    int pe_cyc = -1, se_cyc = -1, oe_cyc = -1, bd_cyc = -1, dv_rise_cyc = -1;
    logic dv_prev = 1'b0;
    int b_pe, b_se, b_oe, b_bd, b_dv_hi, b_dv_rise;
    int k, k2;

    uart_rx_flex #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_IN         (RX_IN),
        .PAR_EN        (PAR_EN),
        .PAR_TYP       (PAR_TYP),
        .STOP2         (STOP2),
        .Prescale      (Prescale),
        .RX_READY      (RX_READY),
        .P_DATA        (P_DATA),
        .data_valid    (data_valid),
        .Parity_Error  (Parity_Error),
        .Stop_Error    (Stop_Error),
        .Overrun_Error (Overrun_Error),
        .Break_Detect  (Break_Detect),
        .busy          (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Pulse/level bookkeeping, sampled away from the active edge.
    always @(negedge CLK) begin
        if (Parity_Error)  begin pe_hi++; pe_cyc = cyc; end
        if (Stop_Error)    begin se_hi++; se_cyc = cyc; end
        if (Overrun_Error) begin oe_hi++; oe_cyc = cyc; end
        if (Break_Detect)  begin bd_hi++; bd_cyc = cyc; end
        if (data_valid)    dv_hi++;
        if (data_valid && !dv_prev) begin dv_rise++; dv_rise_cyc = cyc; end
        dv_prev = data_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_pe = pe_hi; b_se = se_hi; b_oe = oe_hi; b_bd = bd_hi;
        b_dv_hi = dv_hi; b_dv_rise = dv_rise;
    endtask

    task automatic align();
        @(posedge CLK); #1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit has_par, input logic par,
                              input logic s1, input bit two_stop, input logic s2,
                              input int p, output int kk);
        kk = cyc;
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(data[i], p);
        if (has_par)  drive_bit(par, p);
        drive_bit(s1, p);
        if (two_stop) drive_bit(s2, p);
        RX_IN = 1'b1;
    endtask

    initial begin
        RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        Prescale = 6'd16; RX_READY = 1'b1;
        settle(3);
        check("reset_pdata", 32'(P_DATA), 32'h0);
        check("reset_out", {27'h0, data_valid, Parity_Error, Stop_Error, Overrun_Error, Break_Detect},
              32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        RST = 1'b1;
        settle(4);

        // P=16 8N1 0xA5, ready high: one-cycle valid, one clock after final stop tick
        align(); snap();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16, k);
        settle(10);
        check("a5_data", 32'(P_DATA), 32'hA5);
        check("a5_dv_rise", 32'(dv_rise - b_dv_rise), 32'd1);
        check("a5_dv_cyc", 32'(dv_rise_cyc), 32'(k + 157));
        check("a5_dv_width", 32'(dv_hi - b_dv_hi), 32'd1);
        check("a5_flags", 32'((pe_hi - b_pe) + (se_hi - b_se) + (oe_hi - b_oe) + (bd_hi - b_bd)), 32'd0);
        check("a5_busy", 32'(busy), 32'h0);

        // P=5 even parity, 0x3C with wrong parity bit 1
        Prescale = 6'd5; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        align(); snap();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5, k);
        settle(10);
        check("par_err_cnt", 32'(pe_hi - b_pe), 32'd1);
        check("par_err_cyc", 32'(pe_cyc), 32'(k + 57));
        check("par_err_dv", 32'(dv_rise - b_dv_rise), 32'd0);
        check("par_err_data", 32'(P_DATA), 32'hA5);
        check("par_err_stop", 32'(se_hi - b_se), 32'd0);

        // Same word with the correct parity bit loads
        align(); snap();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5, k);
        settle(10);
        check("par_ok_data", 32'(P_DATA), 32'h3C);
        check("par_ok_dv", 32'(dv_rise - b_dv_rise), 32'd1);
        check("par_ok_pe", 32'(pe_hi - b_pe), 32'd0);

        // P=8, 3-clock low glitch: back to idle at the start tick
        Prescale = 6'd8; PAR_EN = 1'b0;
        align(); snap();
        k = cyc;
        RX_IN = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RX_IN = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("glitch_busy_hi", 32'(busy), 32'h1);
        repeat (7) @(posedge CLK);
        @(negedge CLK);
        check("glitch_cyc", 32'(cyc), 32'(k + 12));
        check("glitch_busy_lo", 32'(busy), 32'h0);
        settle(20);
        check("glitch_flags", 32'((pe_hi - b_pe) + (se_hi - b_se) + (oe_hi - b_oe) + (bd_hi - b_bd)), 32'd0);
        check("glitch_dv", 32'(dv_rise - b_dv_rise), 32'd0);

        // P=16, two stop bits, second stop low
        Prescale = 6'd16; STOP2 = 1'b1;
        align(); snap();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16, k);
        settle(10);
        check("stop2_se", 32'(se_hi - b_se), 32'd1);
        check("stop2_se_cyc", 32'(se_cyc), 32'(k + 173));
        check("stop2_bd", 32'(bd_hi - b_bd), 32'd0);
        check("stop2_dv", 32'(dv_rise - b_dv_rise), 32'd0);
        check("stop2_data", 32'(P_DATA), 32'h3C);

        // Break: zero data, zero stop bits
        align(); snap();
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16, k);
        settle(10);
        check("brk_bd", 32'(bd_hi - b_bd), 32'd1);
        check("brk_se", 32'(se_hi - b_se), 32'd1);
        check("brk_same_cyc", 32'(bd_cyc), 32'(se_cyc));
        check("brk_dv", 32'(dv_rise - b_dv_rise), 32'd0);
        check("brk_data", 32'(P_DATA), 32'h3C);

        // Overrun: back-to-back 0x11, 0x22 with consumer stalled
        STOP2 = 1'b0; RX_READY = 1'b0;
        align(); snap();
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16, k);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16, k2);
        settle(10);
        check("ovr_data", 32'(P_DATA), 32'h11);
        check("ovr_dv", 32'(data_valid), 32'h1);
        check("ovr_oe", 32'(oe_hi - b_oe), 32'd1);
        check("ovr_oe_cyc", 32'(oe_cyc), 32'(k2 + 157));
        check("ovr_dv_rise", 32'(dv_rise - b_dv_rise), 32'd1);
        align();
        RX_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("ovr_dv_clear", 32'(data_valid), 32'h0);
        check("ovr_data_kept", 32'(P_DATA), 32'h11);

        // P=32, reset during data bit 3
        Prescale = 6'd32; RX_READY = 1'b0;
        align();
        drive_bit(1'b0, 32);
        drive_bit(1'b1, 32);
        drive_bit(1'b0, 32);
        drive_bit(1'b1, 32);
        drive_bit(1'b0, 10);
        check("rst_pre_busy", 32'(busy), 32'h1);
        RST = 1'b0; RX_IN = 1'b1;
        #1;
        check("rst_pdata", 32'(P_DATA), 32'h0);
        check("rst_dv_busy", {30'h0, data_valid, busy}, 32'h0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        settle(4);
        align(); snap();
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32, k);
        settle(10);
        check("post_rst_data", 32'(P_DATA), 32'h7E);
        check("post_rst_dv", 32'(data_valid), 32'h1);
        check("post_rst_rise", 32'(dv_rise - b_dv_rise), 32'd1);
        check("post_rst_flags", 32'((pe_hi - b_pe) + (se_hi - b_se) + (oe_hi - b_oe) + (bd_hi - b_bd)), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
